// File: rtl/bmem_arbiter.sv
// Round-robin arbiter sharing one burst-memory port between the OoO and pipelined cores.
// Grants whole transactions (one read or one write burst) and routes read beats to the owner.
module bmem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic [ADDR_WIDTH-1:0] ooo_bmem_addr,
    input  logic                  ooo_bmem_read,
    input  logic                  ooo_bmem_write,
    input  logic [DATA_WIDTH-1:0] ooo_bmem_wdata,
    output logic                  ooo_bmem_ready,
    output logic [ADDR_WIDTH-1:0] ooo_bmem_raddr,
    output logic [DATA_WIDTH-1:0] ooo_bmem_rdata,
    output logic                  ooo_bmem_rvalid,

    input  logic [ADDR_WIDTH-1:0] ppl_bmem_addr,
    input  logic                  ppl_bmem_read,
    input  logic                  ppl_bmem_write,
    input  logic [DATA_WIDTH-1:0] ppl_bmem_wdata,
    output logic                  ppl_bmem_ready,
    output logic [ADDR_WIDTH-1:0] ppl_bmem_raddr,
    output logic [DATA_WIDTH-1:0] ppl_bmem_rdata,
    output logic                  ppl_bmem_rvalid,

    output logic [ADDR_WIDTH-1:0] bmem_addr,
    output logic                  bmem_read,
    output logic                  bmem_write,
    output logic [DATA_WIDTH-1:0] bmem_wdata,
    input  logic                  bmem_ready,
    input  logic [ADDR_WIDTH-1:0] bmem_raddr,
    input  logic [DATA_WIDTH-1:0] bmem_rdata,
    input  logic                  bmem_rvalid,

    output logic                  busy
);

    localparam int unsigned CNT_W = $clog2(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_RDWAIT
    } state_e;

    state_e           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic                  req0, req1;
    logic                  own_read, own_write;
    logic [ADDR_WIDTH-1:0] own_addr;
    logic [DATA_WIDTH-1:0] own_wdata;

    assign req0      = ooo_bmem_read | ooo_bmem_write;
    assign req1      = ppl_bmem_read | ppl_bmem_write;
    assign own_read  = owner_q ? ppl_bmem_read  : ooo_bmem_read;
    assign own_write = owner_q ? ppl_bmem_write : ooo_bmem_write;
    assign own_addr  = owner_q ? ppl_bmem_addr  : ooo_bmem_addr;
    assign own_wdata = owner_q ? ppl_bmem_wdata : ooo_bmem_wdata;

    // Return data goes to both sides; only the owner's rvalid qualifies it.
    assign ooo_bmem_raddr = bmem_raddr;
    assign ooo_bmem_rdata = bmem_rdata;
    assign ppl_bmem_raddr = bmem_raddr;
    assign ppl_bmem_rdata = bmem_rdata;
    assign busy           = (state_q != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        last_grant_d    = last_grant_q;
        beat_cnt_d      = beat_cnt_q;
        bmem_addr       = '0;
        bmem_read       = 1'b0;
        bmem_write      = 1'b0;
        bmem_wdata      = '0;
        ooo_bmem_ready  = 1'b0;
        ppl_bmem_ready  = 1'b0;
        ooo_bmem_rvalid = 1'b0;
        ppl_bmem_rvalid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    // On a tie the requester that did not finish last wins.
                    if (req0 && req1) begin
                        owner_d = ~last_grant_q;
                    end else begin
                        owner_d = req1;
                    end
                    state_d = ST_GRANT;
                end
            end

            ST_GRANT: begin
                bmem_addr      = own_addr;
                bmem_read      = own_read;
                bmem_write     = own_write;
                bmem_wdata     = own_wdata;
                ooo_bmem_ready = ~owner_q & bmem_ready;
                ppl_bmem_ready = owner_q & bmem_ready;
                if (own_read && bmem_ready) begin
                    state_d    = ST_RDWAIT;
                    beat_cnt_d = '0;
                end else if (own_write && bmem_ready) begin
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d      = ST_IDLE;
                        last_grant_d = owner_q;
                        beat_cnt_d   = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end else if (!own_read && !own_write && beat_cnt_q == '0) begin
                    // Request withdrawn before any beat: release without affecting fairness.
                    state_d = ST_IDLE;
                end
            end

            ST_RDWAIT: begin
                if (bmem_rvalid) begin
                    ooo_bmem_rvalid = ~owner_q;
                    ppl_bmem_rvalid = owner_q;
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d      = ST_IDLE;
                        last_grant_d = owner_q;
                        beat_cnt_d   = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
